// File: rtl/kbd_pkg.sv
// Shared keyboard/encoder definitions: event type codes, quadrature phase
// constants, the encoder output FSM state type and a phase-order helper.
package kbd_pkg;

  // Event type field, bits [7:6] of an 8-bit keyboard event.
  localparam logic [1:0] EV_TYPE_KEY_PRESS   = 2'b01;
  localparam logic [1:0] EV_TYPE_KEY_RELEASE = 2'b10;
  localparam logic [1:0] EV_TYPE_ENC         = 2'b11;

  // Quadrature phases written as {A,B}; 11 is the detent rest position.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;

  // Encoder index field width inside the event byte.
  localparam int ENC_IDX_W = 2;

  // Output FSM states.
  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_PRESENT = 2'd1,
    OUT_GAP     = 2'd2
  } outState_t;

  // Next phase in clockwise order: 11 -> 01 -> 00 -> 10 -> 11.
  function automatic logic [1:0] cwNext(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_11:   nxt = PH_01;
      PH_01:   nxt = PH_00;
      PH_00:   nxt = PH_10;
      default: nxt = PH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/enc_channel.sv
// One rotary encoder: synchroniser, debounce, phase tracking, step
// accumulator and the signed saturating pending-detent counter.
module enc_channel
  import kbd_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter int STEPS   = 4,
  parameter int PEND_W  = 3
) (
  input  logic                     keyClkScan,
  input  logic                     rst,
  input  logic                     lineA,
  input  logic                     lineB,
  input  logic                     dec,
  output logic signed [PEND_W-1:0] pendCount,
  output logic                     sat
);

  localparam logic [3:0]               DEB_MAX  = 4'(DEB_CYC - 1);
  localparam logic signed [3:0]        ACC_POS  = 4'(STEPS);
  localparam logic signed [3:0]        ACC_NEG  = 4'(-STEPS);
  localparam logic signed [3:0]        ACC_ONE  = 4'sd1;
  localparam int                       PEND_LIM = (1 << (PEND_W - 1)) - 1;
  localparam logic signed [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_LIM);
  localparam logic signed [PEND_W-1:0] PEND_MIN = PEND_W'(-PEND_LIM);
  localparam logic signed [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [1:0]               syncQ1;
  logic [1:0]               syncQ2;
  logic [3:0]               debCnt;
  logic                     accept;
  logic [1:0]               phase;
  logic signed [3:0]        acc;
  logic signed [3:0]        accSum;
  logic                     stepCw;
  logic                     stepCcw;
  logic                     hitCw;
  logic                     hitCcw;
  logic                     detCw;
  logic                     detCcw;
  logic                     pendPos;
  logic                     pendNeg;
  logic signed [PEND_W-1:0] pendAfterDec;
  logic signed [PEND_W-1:0] pendNext;

  // Two-flop synchroniser on {A,B}; idle lines are high.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      syncQ1 <= PH_11;
      syncQ2 <= PH_11;
    end else begin
      syncQ1 <= {lineA, lineB};
      syncQ2 <= syncQ1;
    end
  end

  // Stability counter: any change restarts it, it parks at DEB_CYC-1.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      debCnt <= '0;
    end else if (syncQ1 != syncQ2) begin
      debCnt <= '0;
    end else if (debCnt != DEB_MAX) begin
      debCnt <= debCnt + 4'd1;
    end
  end

  assign accept = (syncQ1 == syncQ2) && (debCnt == DEB_MAX);

  // Classify the accepted transition; diagonal jumps match neither direction.
  always_comb begin
    stepCw  = accept && (syncQ2 == cwNext(phase));
    stepCcw = accept && (phase == cwNext(syncQ2));
    accSum  = acc;
    if (stepCw) begin
      accSum = acc + ACC_ONE;
    end else if (stepCcw) begin
      accSum = acc - ACC_ONE;
    end
    hitCw  = stepCw && (accSum == ACC_POS);
    hitCcw = stepCcw && (accSum == ACC_NEG);
  end

  // Phase and accumulator update; a detent or the rest phase clears the sum.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      phase  <= PH_11;
      acc    <= '0;
      detCw  <= 1'b0;
      detCcw <= 1'b0;
    end else begin
      detCw  <= hitCw;
      detCcw <= hitCcw;
      if (accept) begin
        phase <= syncQ2;
        if (hitCw || hitCcw || (syncQ2 == PH_11)) begin
          acc <= '0;
        end else begin
          acc <= accSum;
        end
      end
    end
  end

  assign pendNeg = pendCount[PEND_W-1];
  assign pendPos = !pendNeg && (pendCount != '0);

  // Pending count: consumer step toward zero first, then the new detent,
  // so a same-cycle ack and detent both take effect.
  always_comb begin
    pendAfterDec = pendCount;
    if (dec && pendPos) begin
      pendAfterDec = pendCount - PEND_ONE;
    end else if (dec && pendNeg) begin
      pendAfterDec = pendCount + PEND_ONE;
    end
    pendNext = pendAfterDec;
    sat      = 1'b0;
    if (detCw) begin
      if (pendAfterDec == PEND_MAX) begin
        sat = 1'b1;
      end else begin
        pendNext = pendAfterDec + PEND_ONE;
      end
    end else if (detCcw) begin
      if (pendAfterDec == PEND_MIN) begin
        sat = 1'b1;
      end else begin
        pendNext = pendAfterDec - PEND_ONE;
      end
    end
  end

  // Pending counter register.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      pendCount <= '0;
    end else begin
      pendCount <= pendNext;
    end
  end

endmodule

// File: rtl/enc_quad_decoder.sv
// Quadrature decoder for the front-panel encoders. Channels count detents;
// this level arbitrates round-robin and emits 8-bit keyboard-format events.
//
// Handshake: encEvReady high means encEvent is valid and stays stable; the
// event is consumed on a clock edge where encEvReady and encEvAck are both
// high. encEvAck has no effect while encEvReady is low.
module enc_quad_decoder
  import kbd_pkg::*;
#(
  parameter int NUM_ENC = 4,
  parameter int DEB_CYC = 4,
  parameter int STEPS   = 4,
  parameter int PEND_W  = 3
) (
  input  logic               keyClkScan,
  input  logic               rst,
  input  logic [NUM_ENC-1:0] encLinesA,
  input  logic [NUM_ENC-1:0] encLinesB,
  input  logic               encEvAck,
  output logic               encEvReady,
  output logic [7:0]         encEvent,
  output logic               encOverflow,
  output logic [1:0]         dbgState
);

  outState_t                state;
  outState_t                stateNext;
  logic signed [PEND_W-1:0] pendVec [NUM_ENC];
  logic [NUM_ENC-1:0]       satVec;
  logic [NUM_ENC-1:0]       decVec;
  logic [ENC_IDX_W-1:0]     rrPtr;
  logic [ENC_IDX_W-1:0]     selIdx;
  logic [ENC_IDX_W-1:0]     pickIdx;
  logic [ENC_IDX_W-1:0]     cand;
  logic                     pickValid;
  logic                     latchEv;
  logic                     ackTake;

  for (genvar i = 0; i < NUM_ENC; i++) begin : gChan
    enc_channel #(
      .DEB_CYC (DEB_CYC),
      .STEPS   (STEPS),
      .PEND_W  (PEND_W)
    ) uChan (
      .keyClkScan (keyClkScan),
      .rst        (rst),
      .lineA      (encLinesA[i]),
      .lineB      (encLinesB[i]),
      .dec        (decVec[i]),
      .pendCount  (pendVec[i]),
      .sat        (satVec[i])
    );
  end

  // Round-robin pick: first nonzero pending count starting at rrPtr.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_ENC; k++) begin
      cand = ENC_IDX_W'((int'(rrPtr) + k) % NUM_ENC);
      if (!pickValid && (pendVec[cand] != '0)) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      state <= OUT_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Output FSM next state.
  always_comb begin
    stateNext = state;
    case (state)
      OUT_IDLE:    if (pickValid) stateNext = OUT_PRESENT;
      OUT_PRESENT: if (encEvAck)  stateNext = OUT_GAP;
      OUT_GAP:     stateNext = OUT_IDLE;
      default:     stateNext = OUT_IDLE;
    endcase
  end

  // Output FSM decode: ready, latch strobe and the consumer decrement.
  always_comb begin
    encEvReady = (state == OUT_PRESENT);
    latchEv    = (state == OUT_IDLE) && pickValid;
    ackTake    = (state == OUT_PRESENT) && encEvAck;
    decVec     = '0;
    if (ackTake) begin
      decVec[selIdx] = 1'b1;
    end
  end

  // Event latch and round-robin pointer; the pointer moves past the served encoder.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      encEvent <= 8'h00;
      selIdx   <= '0;
      rrPtr    <= '0;
    end else begin
      if (latchEv) begin
        selIdx   <= pickIdx;
        encEvent <= {EV_TYPE_ENC, 3'b000, pickIdx, ~pendVec[pickIdx][PEND_W-1]};
      end
      if (ackTake) begin
        rrPtr <= (int'(selIdx) == NUM_ENC - 1) ? '0 : selIdx + 1'b1;
      end
    end
  end

  // Sticky overflow: any detent dropped by a saturated pending counter.
  always_ff @(posedge keyClkScan or posedge rst) begin
    if (rst) begin
      encOverflow <= 1'b0;
    end else if (|satVec) begin
      encOverflow <= 1'b1;
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_enc_quad_decoder.sv
// Bench for enc_quad_decoder: encoder turn drivers, an expected-event queue
// consumed by the ack driver, and a single summary line.
module tb_enc_quad_decoder;

  logic       keyClkScan = 1'b0;
  logic       rst;
  logic [3:0] encLinesA;
  logic [3:0] encLinesB;
  logic       encEvAck;
  logic       encEvReady;
  logic [7:0] encEvent;
  logic       encOverflow;
  logic [1:0] dbgState;

  int         errCnt = 0;
  int         chkCnt = 0;
  logic [7:0] exp_q[$];

  logic [1:0] cwSeq  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] ccwSeq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

  enc_quad_decoder #(
    .NUM_ENC (4),
    .DEB_CYC (4),
    .STEPS   (4),
    .PEND_W  (3)
  ) dut (
    .keyClkScan  (keyClkScan),
    .rst         (rst),
    .encLinesA   (encLinesA),
    .encLinesB   (encLinesB),
    .encEvAck    (encEvAck),
    .encEvReady  (encEvReady),
    .encEvent    (encEvent),
    .encOverflow (encOverflow),
    .dbgState    (dbgState)
  );

  // Clock
  always #5 keyClkScan = ~keyClkScan;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] encEv(input int idx, input bit cw);
    logic [1:0] idxBits;
    idxBits = idx[1:0];
    return {2'b11, 3'b000, idxBits, cw};
  endfunction

  // Drive one phase on every encoder selected by mask and hold it.
  task automatic setPhase(input logic [3:0] mask, input logic [1:0] ph, input int hold);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        encLinesA[i] = ph[1];
        encLinesB[i] = ph[0];
      end
    end
    repeat (hold) @(negedge keyClkScan);
  endtask

  task automatic turn(input logic [3:0] mask, input bit cw, input int detents);
    for (int d = 0; d < detents; d++) begin
      for (int p = 0; p < 4; p++) begin
        setPhase(mask, cw ? cwSeq[p] : ccwSeq[p], 8);
      end
    end
  endtask

  // Wait for an event, compare to the queue head, check stability, ack it.
  task automatic expectEvent(input string tag, input bit chkGap);
    int         w;
    logic [7:0] exp;
    w = 0;
    while (encEvReady !== 1'b1 && w < 300) begin
      @(negedge keyClkScan);
      w++;
    end
    chk({tag, "_ready"}, encEvReady, 1'b1);
    if (encEvReady !== 1'b1) return;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, encEvent, 8'h00);
      exp = encEvent;
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_event"}, encEvent, exp);
    end
    if (chkGap) chk({tag, "_gap"}, w, 2);
    @(negedge keyClkScan);
    chk({tag, "_hold"}, {encEvReady, encEvent}, {1'b1, exp});
    encEvAck = 1'b1;
    @(negedge keyClkScan);
    encEvAck = 1'b0;
    chk({tag, "_drop"}, encEvReady, 1'b0);
  endtask

  // No event may appear for the window and nothing may remain expected.
  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge keyClkScan);
      if (encEvReady !== 1'b0) seen++;
    end
    chk({tag, "_quiet"}, seen, 0);
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int bad;
    int w;
    rst       = 1'b1;
    encLinesA = 4'hF;
    encLinesB = 4'hF;
    encEvAck  = 1'b0;
    repeat (3) @(negedge keyClkScan);
    chk("rst_outs", {encEvReady, encEvent, encOverflow}, 10'h000);
    chk("rst_state", dbgState, 2'd0);
    rst = 1'b0;

    // Idle lines, acks toggling: nothing must come out.
    bad = 0;
    repeat (100) begin
      @(negedge keyClkScan);
      encEvAck = $urandom_range(0, 1);
      if (encEvReady !== 1'b0 || encEvent !== 8'h00 || encOverflow !== 1'b0) bad++;
    end
    encEvAck = 1'b0;
    chk("idle_100", bad, 0);

    // Enc0 one CW detent.
    exp_q.push_back(encEv(0, 1'b1));
    turn(4'b0001, 1'b1, 1);
    expectEvent("e0_cw", 1'b0);
    quiet("e0_cw", 40);

    // Enc2 one CCW detent.
    exp_q.push_back(encEv(2, 1'b0));
    turn(4'b0100, 1'b0, 1);
    expectEvent("e2_ccw", 1'b0);
    quiet("e2_ccw", 40);

    // Enc3 short A pulses, below the debounce length.
    repeat (6) begin
      encLinesA[3] = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge keyClkScan);
      encLinesA[3] = 1'b1;
      repeat (3) @(negedge keyClkScan);
    end
    quiet("e3_glitch", 60);

    // Enc1 three CW detents, ack withheld; back-to-back at minimum spacing.
    repeat (3) exp_q.push_back(encEv(1, 1'b1));
    turn(4'b0010, 1'b1, 3);
    expectEvent("e1_cw3a", 1'b0);
    expectEvent("e1_cw3b", 1'b1);
    expectEvent("e1_cw3c", 1'b1);
    quiet("e1_cw3", 40);

    // Enc1 two CW then one CCW: net one event.
    exp_q.push_back(encEv(1, 1'b1));
    turn(4'b0010, 1'b1, 2);
    turn(4'b0010, 1'b0, 1);
    expectEvent("e1_net", 1'b0);
    quiet("e1_net", 40);

    // Enc3 single CW puts the round-robin start back at enc0.
    exp_q.push_back(encEv(3, 1'b1));
    turn(4'b1000, 1'b1, 1);
    expectEvent("e3_cw", 1'b0);
    quiet("e3_cw", 20);

    // Enc0 and enc3 together, enc0 twice: round-robin order 0,3,0.
    exp_q.push_back(encEv(0, 1'b1));
    exp_q.push_back(encEv(3, 1'b1));
    exp_q.push_back(encEv(0, 1'b1));
    turn(4'b1001, 1'b1, 1);
    turn(4'b0001, 1'b1, 1);
    expectEvent("rr_a", 1'b0);
    expectEvent("rr_b", 1'b1);
    expectEvent("rr_c", 1'b1);
    quiet("rr", 40);

    // Enc0 four CW detents, no ack: pending saturates at 3.
    chk("ovf_before", encOverflow, 1'b0);
    repeat (3) exp_q.push_back(encEv(0, 1'b1));
    turn(4'b0001, 1'b1, 4);
    repeat (4) @(negedge keyClkScan);
    chk("ovf_set", encOverflow, 1'b1);
    expectEvent("sat_a", 1'b0);
    expectEvent("sat_b", 1'b1);
    expectEvent("sat_c", 1'b1);
    quiet("sat", 40);
    chk("ovf_sticky", encOverflow, 1'b1);

    // Reset during PRESENT clears outputs at once and discards pending.
    turn(4'b0001, 1'b1, 1);
    w = 0;
    while (encEvReady !== 1'b1 && w < 300) begin
      @(negedge keyClkScan);
      w++;
    end
    chk("rstp_ready", encEvReady, 1'b1);
    chk("rstp_event", encEvent, encEv(0, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("rstp_outs", {encEvReady, encEvent, encOverflow}, 10'h000);
    @(negedge keyClkScan);
    rst = 1'b0;
    quiet("rstp", 60);
    chk("rstp_ovf", encOverflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
